ternary_op_sequencer: RTL and testbench

//   Applies one ternary two-operand function (min/max/any/consensus) across two TRITS-wide words.

---
 rtl/ternary_op_sequencer.sv | 167 ++++++++++++++++
 tb/tb_ternary_op_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ternary_op_sequencer.sv
// Trit-serial ternary logic unit: applies min/max/any/consensus across two TRITS-wide words,
// one trit per clock through a single shared trit-op datapath, with valid/ready on both sides.
module ternary_op_sequencer #(
    parameter int TRITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [1:0]         op,
    input  logic [2*TRITS-1:0] a,
    input  logic [2*TRITS-1:0] b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*TRITS-1:0] result,
    output logic               err
);

    localparam int IW = (TRITS > 1) ? $clog2(TRITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(TRITS - 1);

    localparam logic [1:0] T_NEG = 2'b00;
    localparam logic [1:0] T_ZERO = 2'b01;
    localparam logic [1:0] T_POS = 2'b10;
    localparam logic [1:0] T_BAD = 2'b11;

    localparam logic [1:0] OP_MIN = 2'b00;
    localparam logic [1:0] OP_MAX = 2'b01;
    localparam logic [1:0] OP_ANY = 2'b10;
    localparam logic [1:0] OP_CONS = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t stateReg, stateNext;

    logic [1:0]    opReg;
    logic [IW-1:0] idxReg;
    logic          errReg;
    logic [1:0]    aTrit      [TRITS];
    logic [1:0]    bTrit      [TRITS];
    logic [1:0]    resultTrit [TRITS];

    logic accept;
    logic handshake;
    logic [1:0] curA;
    logic [1:0] curB;
    logic [1:0] tritRes;
    logic       tritErr;

    assign accept    = (stateReg == IDLE) && start_valid;
    assign handshake = (stateReg == DONE) && res_ready;

    // Pure two-operand trit function; invalid codes are handled by the caller.
    function automatic logic [1:0] tritOp(input logic [1:0] f, input logic [1:0] x,
                                          input logic [1:0] y);
        logic xp, yp, xn, yn;
        xp = (x == T_POS);
        yp = (y == T_POS);
        xn = (x == T_NEG);
        yn = (y == T_NEG);
        tritOp = T_ZERO;
        case (f)
            OP_MIN: begin
                if (xn || yn)      tritOp = T_NEG;
                else if (xp && yp) tritOp = T_POS;
            end
            OP_MAX: begin
                if (xp || yp)      tritOp = T_POS;
                else if (xn && yn) tritOp = T_NEG;
            end
            OP_ANY: begin
                if ((xp || yp) && !xn && !yn)      tritOp = T_POS;
                else if ((xn || yn) && !xp && !yp) tritOp = T_NEG;
            end
            OP_CONS: begin
                if ((x == y) && (x != T_ZERO)) tritOp = x;
            end
            default: tritOp = T_ZERO;
        endcase
    endfunction

    // Per-trit operand latches and result registers; only the indexed result trit updates in RUN.
    genvar gi;
    generate
        for (gi = 0; gi < TRITS; gi++) begin : g_trit
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    aTrit[gi]      <= T_ZERO;
                    bTrit[gi]      <= T_ZERO;
                    resultTrit[gi] <= T_ZERO;
                end else if (accept) begin
                    aTrit[gi]      <= a[2*gi +: 2];
                    bTrit[gi]      <= b[2*gi +: 2];
                    resultTrit[gi] <= T_ZERO;
                end else if ((stateReg == RUN) && (idxReg == IW'(gi))) begin
                    resultTrit[gi] <= tritRes;
                end
            end

            assign result[2*gi +: 2] = resultTrit[gi];
        end
    endgenerate

    // Shared datapath: select the current trit pair and evaluate once per cycle.
    always_comb begin
        curA = T_ZERO;
        curB = T_ZERO;
        for (int i = 0; i < TRITS; i++) begin
            if (idxReg == IW'(i)) begin
                curA = aTrit[i];
                curB = bTrit[i];
            end
        end
    end

    always_comb begin
        tritErr = (curA == T_BAD) || (curB == T_BAD);
        tritRes = tritErr ? T_ZERO : tritOp(opReg, curA, curB);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (accept) stateNext = RUN;
            RUN:     if (idxReg == LAST_IDX) stateNext = DONE;
            DONE:    if (handshake) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        start_ready = (stateReg == IDLE);
        res_valid   = (stateReg == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opReg  <= OP_MIN;
            idxReg <= '0;
            errReg <= 1'b0;
        end else if (accept) begin
            opReg  <= op;
            idxReg <= '0;
            errReg <= 1'b0;
        end else if (stateReg == RUN) begin
            errReg <= errReg | tritErr;
            if (idxReg != LAST_IDX) begin
                idxReg <= idxReg + 1'b1;
            end
        end
    end

    assign err = errReg;

endmodule

// File: tb/tb_ternary_op_sequencer.sv
// Directed bench for ternary_op_sequencer (TRITS=4): vector table plus backpressure,
// input-stability and mid-run reset sequences.
module tb_ternary_op_sequencer;

    logic       clk;
    logic       rst;
    logic       start_valid;
    logic       start_ready;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] result;
    logic       err;

    int totalCnt = 0;
    int passCnt  = 0;

    ternary_op_sequencer #(.TRITS(4)) dut (
        .clk(clk),
        .rst(rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .op(op),
        .a(a),
        .b(b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .result(result),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) begin
            passCnt++;
            $display("check %-22s got 0x%0h expected 0x%0h ok", name, act, exp);
        end else begin
            $display("FAIL %-22s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a command at the falling edge and let the next rising edge accept it;
    // afterwards the operand inputs are scrambled to show they are not re-sampled.
    task automatic issue(input logic [1:0] o, input logic [7:0] va, input logic [7:0] vb);
        @(negedge clk);
        start_valid = 1'b1;
        op = o;
        a  = va;
        b  = vb;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        op = ~o;
        a  = 8'($urandom);
        b  = 8'($urandom);
    endtask

    task automatic waitDone(output int edges);
        edges = 0;
        while (!res_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int edges;
        logic [7:0] held;

        vecs[0] = '{2'b00, 8'h92, 8'hA8, 8'h90, 1'b0};
        vecs[1] = '{2'b01, 8'h92, 8'hA8, 8'hAA, 1'b0};
        vecs[2] = '{2'b11, 8'h90, 8'h90, 8'h90, 1'b0};
        vecs[3] = '{2'b10, 8'hA1, 8'h22, 8'h62, 1'b0};
        vecs[4] = '{2'b10, 8'hA1, 8'h28, 8'h64, 1'b0};
        vecs[5] = '{2'b10, 8'hFF, 8'h55, 8'h55, 1'b1};
        vecs[6] = '{2'b00, 8'h92, 8'hA8, 8'h90, 1'b0};
        vecs[7] = '{2'b11, 8'h92, 8'hA8, 8'h95, 1'b0};
        vecs[8] = '{2'b00, 8'hB2, 8'hA8, 8'h90, 1'b1};

        rst = 1'b1;
        start_valid = 1'b0;
        res_ready = 1'b0;
        op = 2'b00;
        a = 8'h00;
        b = 8'h00;
        repeat (2) @(negedge clk);
        check("reset start_ready", 32'(start_ready), 32'd1);
        check("reset res_valid", 32'(res_valid), 32'd0);
        check("reset result", 32'(result), 32'h55);
        check("reset err", 32'(err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d start_ready in run", i), 32'(start_ready), 32'd0);
            waitDone(edges);
            check($sformatf("v%0d latency", i), 32'(edges), 32'd4);
            check($sformatf("v%0d result", i), 32'(result), 32'(vecs[i].res));
            check($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].err));
            consume();
            check($sformatf("v%0d ready after take", i), 32'(start_ready), 32'd1);
            check($sformatf("v%0d valid after take", i), 32'(res_valid), 32'd0);
        end

        // Backpressure with res_ready held low and spurious start_valid pulses.
        issue(2'b01, 8'h92, 8'hA8);
        waitDone(edges);
        check("bp latency", 32'(edges), 32'd4);
        held = result;
        check("bp result", 32'(held), 32'hAA);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            start_valid = (c != 1);
            op = 2'b00;
            a = 8'h00;
            b = 8'h00;
            @(posedge clk);
            #1;
            start_valid = 1'b0;
            check($sformatf("bp%0d res_valid", c), 32'(res_valid), 32'd1);
            check($sformatf("bp%0d result", c), 32'(result), 32'(held));
            check($sformatf("bp%0d start_ready", c), 32'(start_ready), 32'd0);
        end
        consume();
        check("bp ready after take", 32'(start_ready), 32'd1);
        check("bp valid after take", 32'(res_valid), 32'd0);
        check("bp result after take", 32'(result), 32'hAA);

        // res_ready held high during RUN must not shorten the operation.
        issue(2'b00, 8'h92, 8'hA8);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("early ready no valid", 32'(res_valid), 32'd0);
        res_ready = 1'b0;
        waitDone(edges);
        check("early ready latency", 32'(edges), 32'd3);
        check("early ready result", 32'(result), 32'h90);
        consume();

        // Reset after two RUN edges: partial result visible, then dropped asynchronously.
        issue(2'b01, 8'h92, 8'hA8);
        repeat (2) @(posedge clk);
        #1;
        check("midrun partial", 32'(result), 32'h5A);
        rst = 1'b1;
        #1;
        check("midrun res_valid", 32'(res_valid), 32'd0);
        check("midrun start_ready", 32'(start_ready), 32'd1);
        check("midrun result", 32'(result), 32'h55);
        check("midrun err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midrun no result", 32'(res_valid), 32'd0);
        issue(2'b11, 8'h90, 8'h90);
        waitDone(edges);
        check("post reset latency", 32'(edges), 32'd4);
        check("post reset result", 32'(result), 32'h90);
        check("post reset err", 32'(err), 32'd0);
        consume();

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
